// File: rtl/stopwatch_up_mmss.sv
// MM:SS packed-BCD up-counting stopwatch with start/stop/clear FSM and programmable stop limit.
// Optional lap capture port pair enabled by defining STOPWATCH_LAP_EN.
module stopwatch_up_mmss #(
  parameter int unsigned ONES_MAX = 9,
  parameter int unsigned TENS_MAX = 5
) (
  input  logic        clk,
  input  logic        clearn,
  input  logic        en,
  input  logic        start,
  input  logic        stop,
  input  logic        clr,
  input  logic [15:0] limit,
`ifdef STOPWATCH_LAP_EN
  input  logic        lap,
  output logic [15:0] lap_time,
`endif
  output logic [15:0] count,
  output logic        running,
  output logic        done,
  output logic        tc
);

  localparam int unsigned DW = 4;
  localparam int unsigned CW = 4 * DW;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_d;
  logic          tc_d;
  logic [CW-1:0] inc_val;
  logic          wrap;

  // One BCD digit stage: returns {carry_out, next_digit}
  function automatic logic [DW:0] digit_step(input logic [DW-1:0] d, input logic cin,
                                             input logic [DW-1:0] dmax);
    if (!cin)
      return {1'b0, d};
    if (d == dmax)
      return {1'b1, DW'(0)};
    return {1'b0, d + DW'(1)};
  endfunction

  // Cascaded mod-(ONES_MAX+1)/mod-(TENS_MAX+1) increment of the current count
  always_comb begin
    logic [DW:0] s0, s1, s2, s3;
    s0      = digit_step(count[3:0],   1'b1,  DW'(ONES_MAX));
    s1      = digit_step(count[7:4],   s0[DW], DW'(TENS_MAX));
    s2      = digit_step(count[11:8],  s1[DW], DW'(ONES_MAX));
    s3      = digit_step(count[15:12], s2[DW], DW'(TENS_MAX));
    inc_val = {s3[DW-1:0], s2[DW-1:0], s1[DW-1:0], s0[DW-1:0]};
    wrap    = s3[DW];
  end

`ifdef STOPWATCH_LAP_EN
  logic [CW-1:0] lap_d;
`endif

  // Next-state, next-count and pulse logic; clr outranks every other request
  always_comb begin
    state_d = state_q;
    count_d = count;
    tc_d    = 1'b0;
`ifdef STOPWATCH_LAP_EN
    lap_d   = lap_time;
    if (lap && state_q == RUN)
      lap_d = count;
`endif
    if (clr) begin
      state_d = IDLE;
      count_d = '0;
`ifdef STOPWATCH_LAP_EN
      lap_d   = '0;
`endif
    end else begin
      case (state_q)
        IDLE, PAUSE: begin
          if (!stop && start)
            state_d = RUN;
        end
        RUN: begin
          if (stop) begin
            state_d = PAUSE;
          end else if (en) begin
            count_d = inc_val;
            if (limit != '0 && inc_val == limit) begin
              state_d = DONE;
              tc_d    = 1'b1;
            end else if (wrap) begin
              tc_d = 1'b1;
            end
          end
        end
        DONE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  // State, count and registered status decodes
  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      state_q  <= IDLE;
      count    <= '0;
      running  <= 1'b0;
      done     <= 1'b0;
      tc       <= 1'b0;
`ifdef STOPWATCH_LAP_EN
      lap_time <= '0;
`endif
    end else begin
      state_q  <= state_d;
      count    <= count_d;
      running  <= (state_d == RUN);
      done     <= (state_d == DONE);
      tc       <= tc_d;
`ifdef STOPWATCH_LAP_EN
      lap_time <= lap_d;
`endif
    end
  end

endmodule

// File: tb/tb_stopwatch_up_mmss.sv
// Directed self-checking bench for stopwatch_up_mmss (lap checks when STOPWATCH_LAP_EN is defined).
module tb_stopwatch_up_mmss;

  logic        clk = 1'b0;
  logic        clearn;
  logic        en, start, stop, clr;
  logic [15:0] limit;
  logic [15:0] count;
  logic        running, done, tc;
`ifdef STOPWATCH_LAP_EN
  logic        lap;
  logic [15:0] lap_time;
`endif

  int checks = 0;
  int errors = 0;

  stopwatch_up_mmss dut (
    .clk     (clk),
    .clearn  (clearn),
    .en      (en),
    .start   (start),
    .stop    (stop),
    .clr     (clr),
    .limit   (limit),
`ifdef STOPWATCH_LAP_EN
    .lap     (lap),
    .lap_time(lap_time),
`endif
    .count   (count),
    .running (running),
    .done    (done),
    .tc      (tc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clearn = 1'b0; en = 1'b0; start = 1'b0; stop = 1'b0; clr = 1'b0; limit = 16'h0000;
`ifdef STOPWATCH_LAP_EN
    lap = 1'b0;
`endif
    repeat (2) cyc();
    check("rst_count", 32'(count), 32'h0000);
    check("rst_running", 32'(running), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_tc", 32'(tc), 32'd0);
    clearn = 1'b1;

    // count and carry into minutes
    start = 1'b1; cyc(); start = 1'b0;
    check("start_running", 32'(running), 32'd1);
    check("start_count", 32'(count), 32'h0000);
    en = 1'b1;
    repeat (59) cyc();
    check("tick59", 32'(count), 32'h0059);
    cyc();
    check("tick60", 32'(count), 32'h0100);
    check("tick60_tc", 32'(tc), 32'd0);

    // run on to 12:34, then async reset mid-count
    repeat (694) cyc();
    check("at_1234", 32'(count), 32'h1234);
    check("at_1234_running", 32'(running), 32'd1);
    #2 clearn = 1'b0;
    #1;
    check("async_count", 32'(count), 32'h0000);
    check("async_running", 32'(running), 32'd0);
    check("async_done", 32'(done), 32'd0);
    check("async_tc", 32'(tc), 32'd0);
    en = 1'b0;
    cyc();
    clearn = 1'b1;

    // wrap 59:59 -> 00:00
    start = 1'b1; cyc(); start = 1'b0;
    en = 1'b1;
    repeat (3598) cyc();
    check("pre_wrap", 32'(count), 32'h5958);
    cyc();
    check("at_5959", 32'(count), 32'h5959);
    check("at_5959_tc", 32'(tc), 32'd0);
    cyc();
    check("wrap_count", 32'(count), 32'h0000);
    check("wrap_tc", 32'(tc), 32'd1);
    check("wrap_running", 32'(running), 32'd1);
    en = 1'b0;
    cyc();
    check("wrap_tc_drop", 32'(tc), 32'd0);

    // limit reached -> DONE, frozen
    clr = 1'b1; cyc(); clr = 1'b0;
    check("clr_running", 32'(running), 32'd0);
    check("clr_count", 32'(count), 32'h0000);
    limit = 16'h0005;
    start = 1'b1; cyc(); start = 1'b0;
    en = 1'b1;
    repeat (4) cyc();
    check("lim_0004", 32'(count), 32'h0004);
    check("lim_0004_done", 32'(done), 32'd0);
    cyc();
    check("lim_count", 32'(count), 32'h0005);
    check("lim_done", 32'(done), 32'd1);
    check("lim_tc", 32'(tc), 32'd1);
    check("lim_running", 32'(running), 32'd0);
    start = 1'b1;
    cyc();
    cyc();
    start = 1'b0;
    check("done_frozen", 32'(count), 32'h0005);
    check("done_tc_drop", 32'(tc), 32'd0);
    check("done_held", 32'(done), 32'd1);
    en = 1'b0;

    // control priorities
    clr = 1'b1; cyc(); clr = 1'b0;
    limit = 16'h0000;
    check("clr_done", 32'(done), 32'd0);
    start = 1'b1; stop = 1'b1; cyc(); start = 1'b0; stop = 1'b0;
    check("startstop_idle", 32'(running), 32'd0);
    en = 1'b1;
    cyc();
    check("idle_en_ignored", 32'(count), 32'h0000);
    start = 1'b1; cyc(); start = 1'b0;
    check("start_en_running", 32'(running), 32'd1);
    check("start_en_nocount", 32'(count), 32'h0000);
    repeat (3) cyc();
    check("ctl_0003", 32'(count), 32'h0003);
    stop = 1'b1; cyc(); stop = 1'b0;
    check("stop_en_pause", 32'(running), 32'd0);
    check("stop_en_count", 32'(count), 32'h0003);
    cyc();
    check("pause_hold", 32'(count), 32'h0003);
    start = 1'b1; cyc(); start = 1'b0;
    check("resume_running", 32'(running), 32'd1);
    check("resume_nocount", 32'(count), 32'h0003);
    en = 1'b0;
    clr = 1'b1; start = 1'b1; cyc(); clr = 1'b0; start = 1'b0;
    check("clrstart_running", 32'(running), 32'd0);
    check("clrstart_count", 32'(count), 32'h0000);

    // invalid limit digit never matches
    limit = 16'h0070;
    start = 1'b1; cyc(); start = 1'b0;
    en = 1'b1;
    repeat (70) cyc();
    check("badlim_count", 32'(count), 32'h0110);
    check("badlim_done", 32'(done), 32'd0);
    en = 1'b0;
    clr = 1'b1; cyc(); clr = 1'b0;
    limit = 16'h0000;

`ifdef STOPWATCH_LAP_EN
    start = 1'b1; cyc(); start = 1'b0;
    en = 1'b1;
    repeat (9) cyc();
    check("lap_pre", 32'(count), 32'h0009);
    lap = 1'b1; cyc(); lap = 1'b0;
    check("lap_time", 32'(lap_time), 32'h0009);
    check("lap_count", 32'(count), 32'h0010);
    en = 1'b0;
    stop = 1'b1; cyc(); stop = 1'b0;
    en = 1'b1;
    cyc();
    lap = 1'b1; cyc(); lap = 1'b0;
    en = 1'b0;
    check("lap_pause", 32'(lap_time), 32'h0009);
    clr = 1'b1; cyc(); clr = 1'b0;
    check("lap_clr", 32'(lap_time), 32'h0000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
